// File: rtl/e_bus_cycle_seq.sv
// e_bus_cycle_seq
// Sequences the 6809-side address/data bus buffers for one CPU bus cycle at a
// time. E and Q are synchronised into the fast clock domain, and their edges
// drive a per-cycle FSM with these phases: address, data setup, data window,
// hold. A watchdog flags loss of E and parks the sequencer.
//
// Ports:
//   i_clk        fast PLL clock
//   i_reset      asynchronous, active-low reset
//   i_e_clk      6809 E clock (asynchronous)
//   i_q_clk      6809 Q clock (asynchronous)
//   i_rw         6809 R/W (1 = CPU read), latched on synced Q rise
//   i_sel        board address decode hit, latched on synced Q rise
//   o_addr_oe    address buffer enable
//   o_data_oe    data buffer enable
//   o_data_dir   1 = FPGA drives CPU bus, 0 = CPU drives FPGA
//   o_wr_strobe  one-cycle pulse at E fall of a selected write cycle
//   o_busy       sequencer not idle
//   o_e_fault    E clock lost
module e_bus_cycle_seq #(
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_DLY   = 4,
  parameter int HOLD_DLY    = 5,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_e_clk,
  input  logic i_q_clk,
  input  logic i_rw,
  input  logic i_sel,
  output logic o_addr_oe,
  output logic o_data_oe,
  output logic o_data_dir,
  output logic o_wr_strobe,
  output logic o_busy,
  output logic o_e_fault
);

  typedef enum logic [2:0] {IDLE, ADDR, SKIP, SETUP, DATA, HOLD} state_t;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_DLY - 1);
  localparam logic [CNT_W-1:0] WD_MAX   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] WD_PRE   = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] e_sync;
  logic [SYNC_STAGES-1:0] q_sync;
  logic                   e_last;
  logic                   q_last;
  logic                   e_rise;
  logic                   e_fall;
  logic                   q_rise;
  logic                   e_edge;
  logic                   fault_next;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wd;
  logic             rw_q;
  logic             sel_q;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      e_sync <= '0;
      q_sync <= '0;
      e_last <= 1'b0;
      q_last <= 1'b0;
    end else begin
      e_sync <= {e_sync[SYNC_STAGES-2:0], i_e_clk};
      q_sync <= {q_sync[SYNC_STAGES-2:0], i_q_clk};
      e_last <= e_sync[SYNC_STAGES-1];
      q_last <= q_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    e_rise = e_sync[SYNC_STAGES-1] & ~e_last;
    e_fall = ~e_sync[SYNC_STAGES-1] & e_last;
    q_rise = q_sync[SYNC_STAGES-1] & ~q_last;
    e_edge = e_rise | e_fall;
    // wd saturates at TIMEOUT, so the fault stays asserted until an E edge.
    fault_next = ~e_edge & (wd >= WD_PRE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wd        <= '0;
      o_e_fault <= 1'b0;
    end else begin
      o_e_fault <= fault_next;
      if (e_edge)
        wd <= '0;
      else if (wd != WD_MAX)
        wd <= wd + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rw_q        <= 1'b0;
      sel_q       <= 1'b0;
      o_addr_oe   <= 1'b0;
      o_data_oe   <= 1'b0;
      o_data_dir  <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_wr_strobe <= 1'b0;
      if (fault_next) begin
        state     <= IDLE;
        o_addr_oe <= 1'b0;
        o_data_oe <= 1'b0;
        o_busy    <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (q_rise) begin
              state      <= ADDR;
              rw_q       <= i_rw;
              sel_q      <= i_sel;
              o_addr_oe  <= 1'b1;
              o_data_dir <= i_rw;
              o_busy     <= 1'b1;
            end
          end
          ADDR: begin
            if (e_rise) begin
              if (sel_q) begin
                state <= SETUP;
                cnt   <= SETUP_LD;
              end else begin
                state <= SKIP;
              end
            end
          end
          SKIP: begin
            if (e_fall) begin
              state     <= IDLE;
              o_addr_oe <= 1'b0;
              o_busy    <= 1'b0;
            end
          end
          SETUP: begin
            // An early E fall abandons the cycle before the data window opens.
            if (e_fall) begin
              state     <= IDLE;
              o_addr_oe <= 1'b0;
              o_busy    <= 1'b0;
            end else if (cnt == '0) begin
              state     <= DATA;
              o_data_oe <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          DATA: begin
            if (e_fall) begin
              state       <= HOLD;
              cnt         <= HOLD_LD;
              o_addr_oe   <= 1'b0;
              o_wr_strobe <= ~rw_q;
            end
          end
          HOLD: begin
            // A new Q rise truncates the hold and starts the next cycle directly.
            if (q_rise) begin
              state      <= ADDR;
              rw_q       <= i_rw;
              sel_q      <= i_sel;
              o_addr_oe  <= 1'b1;
              o_data_oe  <= 1'b0;
              o_data_dir <= i_rw;
            end else if (cnt == '0) begin
              state     <= IDLE;
              o_data_oe <= 1'b0;
              o_busy    <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state     <= IDLE;
            o_addr_oe <= 1'b0;
            o_data_oe <= 1'b0;
            o_busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_e_bus_cycle_seq.sv
// tb_e_bus_cycle_seq
// Directed bench for e_bus_cycle_seq: read, write, deselected cycle, E-loss
// watchdog, Q rise during hold, and asynchronous reset during the data window.
// Pins change 1 ns after a rising edge; a pin change acts on the FSM at the
// third rising edge after it (two synchroniser flops plus the edge flop).
module tb_e_bus_cycle_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic e_clk = 1'b0;
  logic q_clk = 1'b0;
  logic rw = 1'b0;
  logic sel = 1'b0;
  logic addr_oe;
  logic data_oe;
  logic data_dir;
  logic wr_strobe;
  logic busy;
  logic e_fault;

  int total = 0;
  int bad = 0;
  int strobe_cnt = 0;
  int doe_cnt = 0;

  e_bus_cycle_seq #(
    .SYNC_STAGES(2),
    .SETUP_DLY  (4),
    .HOLD_DLY   (5),
    .TIMEOUT    (255),
    .CNT_W      (8)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_e_clk    (e_clk),
    .i_q_clk    (q_clk),
    .i_rw       (rw),
    .i_sel      (sel),
    .o_addr_oe  (addr_oe),
    .o_data_oe  (data_oe),
    .o_data_dir (data_dir),
    .o_wr_strobe(wr_strobe),
    .o_busy     (busy),
    .o_e_fault  (e_fault)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe === 1'b1) strobe_cnt++;
    if (data_oe === 1'b1) doe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  int s0;

  initial begin
    // reset state
    tick(4);
    check("rst_addr_oe", addr_oe, 1'b0);
    check("rst_data_oe", data_oe, 1'b0);
    check("rst_dir", data_dir, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", e_fault, 1'b0);
    reset = 1'b1;
    tick(2);

    // 1: selected read
    rw = 1'b1; sel = 1'b1; q_clk = 1'b1;
    tick(2);
    check("t1_busy_early", busy, 1'b0);
    tick(1);
    check("t1_busy", busy, 1'b1);
    check("t1_addr_oe", addr_oe, 1'b1);
    check("t1_dir", data_dir, 1'b1);
    tick(22);
    e_clk = 1'b1;
    tick(6);
    check("t1_doe_pre", data_oe, 1'b0);
    tick(1);
    check("t1_doe_rise", data_oe, 1'b1);
    tick(18);
    q_clk = 1'b0;
    tick(25);
    e_clk = 1'b0;
    tick(3);
    check("t1_hold_addr", addr_oe, 1'b0);
    check("t1_hold_doe", data_oe, 1'b1);
    tick(4);
    check("t1_doe_last", data_oe, 1'b1);
    tick(1);
    check("t1_doe_fall", data_oe, 1'b0);
    check("t1_idle", busy, 1'b0);
    check("t1_dir_hold", data_dir, 1'b1);
    check_int("t1_strobes", strobe_cnt, 0);

    // 2: selected write
    tick(10);
    rw = 1'b0; sel = 1'b1; q_clk = 1'b1;
    tick(3);
    check("t2_dir", data_dir, 1'b0);
    check("t2_doe0", data_oe, 1'b0);
    tick(22);
    e_clk = 1'b1;
    tick(7);
    check("t2_doe", data_oe, 1'b1);
    tick(20);
    q_clk = 1'b0;
    tick(20);
    s0 = strobe_cnt;
    e_clk = 1'b0;
    tick(3);
    check("t2_strobe", wr_strobe, 1'b1);
    tick(1);
    check("t2_strobe_end", wr_strobe, 1'b0);
    tick(4);
    check("t2_idle", busy, 1'b0);
    check_int("t2_strobes", strobe_cnt, s0 + 1);

    // 3: deselected cycle
    tick(10);
    s0 = strobe_cnt;
    doe_cnt = 0;
    rw = 1'b1; sel = 1'b0; q_clk = 1'b1;
    tick(3);
    check("t3_addr_oe", addr_oe, 1'b1);
    tick(20);
    e_clk = 1'b1;
    tick(10);
    check("t3_skip_addr", addr_oe, 1'b1);
    check("t3_skip_busy", busy, 1'b1);
    q_clk = 1'b0;
    tick(20);
    e_clk = 1'b0;
    tick(3);
    check("t3_addr_off", addr_oe, 1'b0);
    check("t3_idle", busy, 1'b0);
    check_int("t3_no_doe", doe_cnt, 0);
    check_int("t3_no_strobe", strobe_cnt, s0);

    // 4: E stuck high
    tick(10);
    rw = 1'b1; sel = 1'b1; q_clk = 1'b1;
    tick(20);
    e_clk = 1'b1;
    q_clk = 1'b0;
    tick(10);
    check("t4_doe_on", data_oe, 1'b1);
    tick(247);
    check("t4_no_fault_yet", e_fault, 1'b0);
    check("t4_doe_before", data_oe, 1'b1);
    tick(1);
    check("t4_fault", e_fault, 1'b1);
    check("t4_doe_off", data_oe, 1'b0);
    check("t4_addr_off", addr_oe, 1'b0);
    check("t4_idle", busy, 1'b0);
    tick(42);
    check("t4_fault_held", e_fault, 1'b1);
    e_clk = 1'b0;
    tick(3);
    check("t4_fault_clear", e_fault, 1'b0);
    check("t4_still_idle", busy, 1'b0);

    // 5: Q rise two cycles into hold
    tick(5);
    rw = 1'b1; sel = 1'b1; q_clk = 1'b1;
    tick(20);
    e_clk = 1'b1;
    tick(20);
    q_clk = 1'b0;
    tick(20);
    e_clk = 1'b0;
    tick(2);
    rw = 1'b0; sel = 1'b1; q_clk = 1'b1;
    tick(1);
    check("t5_hold_doe", data_oe, 1'b1);
    check("t5_hold_addr", addr_oe, 1'b0);
    tick(1);
    check("t5_hold2_doe", data_oe, 1'b1);
    check("t5_hold2_dir", data_dir, 1'b1);
    tick(1);
    check("t5_cut_doe", data_oe, 1'b0);
    check("t5_addr", addr_oe, 1'b1);
    check("t5_new_dir", data_dir, 1'b0);
    check("t5_busy", busy, 1'b1);
    s0 = strobe_cnt;
    tick(20);
    e_clk = 1'b1;
    tick(7);
    check("t5_doe", data_oe, 1'b1);
    tick(20);
    q_clk = 1'b0;
    tick(10);
    e_clk = 1'b0;
    tick(3);
    check("t5_strobe", wr_strobe, 1'b1);
    tick(10);
    check_int("t5_strobes", strobe_cnt, s0 + 1);

    // 6: reset in the data window
    rw = 1'b1; sel = 1'b1; q_clk = 1'b1;
    tick(20);
    e_clk = 1'b1;
    tick(10);
    check("t6_doe_on", data_oe, 1'b1);
    #2;
    reset = 1'b0;
    e_clk = 1'b0;
    q_clk = 1'b0;
    #1;
    check("t6_doe_rst", data_oe, 1'b0);
    check("t6_addr_rst", addr_oe, 1'b0);
    check("t6_dir_rst", data_dir, 1'b0);
    check("t6_busy_rst", busy, 1'b0);
    tick(2);
    reset = 1'b1;
    tick(5);
    check("t6_idle", busy, 1'b0);
    check("t6_fault", e_fault, 1'b0);
    rw = 1'b0; sel = 1'b1; q_clk = 1'b1;
    tick(3);
    check("t6_restart", busy, 1'b1);
    check("t6_restart_dir", data_dir, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
